// File: rtl/fp_norm_sequencer.sv
// fp_norm_sequencer: multi-cycle post-add/sub normalizer for the single-precision FPU.
// Takes a raw 25-bit sum mantissa with sign and biased exponent and counts its leading zeros.
// It then left-shifts in SHIFT_STEP-bit chunks, or right-shifts by one bit, and clamps the
// result to the zero, denormal or infinity encoding before it goes to the rounding stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake (ready only while idle)
//   in_sign, in_exp, in_mant sign, biased exponent, raw mantissa (bit24 carry, bit23 hidden)
//   out_valid / out_ready    result handshake; all out_* hold while valid && !ready
//   out_sign, out_exp        sign passthrough, normalized biased exponent
//   out_mant                 normalized mantissa including hidden bit [23]
//   out_guard                bit dropped by the 1-bit right shift
//   out_zero, out_underflow, out_overflow  mutually exclusive result class flags
module fp_norm_sequencer #(
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [23:0] out_mant,
  output logic        out_guard,
  output logic        out_zero,
  output logic        out_underflow,
  output logic        out_overflow
);

  localparam int unsigned EXP_W  = 9;
  localparam int unsigned MANT_W = 25;
  localparam int unsigned REM_W  = 5;
  localparam logic [REM_W-1:0] STEP_R = REM_W'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ANALYZE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic                r_sign,     w_sign_nxt;
  logic [EXP_W-1:0]    r_exp,      w_exp_nxt;
  logic [MANT_W-1:0]   r_mant,     w_mant_nxt;
  logic [REM_W-1:0]    r_rem,      w_rem_nxt;
  logic                r_guard,    w_guard_nxt;
  logic                r_zero,     w_zero_nxt;
  logic                r_udf,      w_udf_nxt;
  logic                r_ovf,      w_ovf_nxt;
  logic                r_in_ready, w_in_ready_nxt;
  logic                r_out_valid, w_out_valid_nxt;

  logic [REM_W-1:0]    w_lz;
  logic [REM_W-1:0]    w_step;

  // Leading-zero count of a 25-bit word; 25 when the word is zero.
  function automatic logic [REM_W-1:0] lzc25(input logic [MANT_W-1:0] v);
    lzc25 = REM_W'(MANT_W);
    for (int i = 0; i < int'(MANT_W); i++) begin
      if (v[i]) lzc25 = REM_W'(int'(MANT_W) - 1 - i);
    end
  endfunction

  assign w_lz   = lzc25(r_mant);
  assign w_step = (r_rem > STEP_R) ? STEP_R : r_rem;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_rem       <= '0;
      r_guard     <= 1'b0;
      r_zero      <= 1'b0;
      r_udf       <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sign      <= w_sign_nxt;
      r_exp       <= w_exp_nxt;
      r_mant      <= w_mant_nxt;
      r_rem       <= w_rem_nxt;
      r_guard     <= w_guard_nxt;
      r_zero      <= w_zero_nxt;
      r_udf       <= w_udf_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_exp_nxt   = r_exp;
    w_mant_nxt  = r_mant;
    w_rem_nxt   = r_rem;
    w_guard_nxt = r_guard;
    w_zero_nxt  = r_zero;
    w_udf_nxt   = r_udf;
    w_ovf_nxt   = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_nxt  = in_sign;
          // Exponent 0 encodes the same scale as exponent 1.
          w_exp_nxt   = (in_exp == 8'd0) ? EXP_W'(1) : {1'b0, in_exp};
          w_mant_nxt  = in_mant;
          w_rem_nxt   = '0;
          w_guard_nxt = 1'b0;
          w_zero_nxt  = 1'b0;
          w_udf_nxt   = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_ANALYZE;
        end
      end

      S_ANALYZE: begin
        w_state_nxt = S_DONE;
        if (w_lz == REM_W'(MANT_W)) begin
          w_exp_nxt  = '0;
          w_mant_nxt = '0;
          w_zero_nxt = 1'b1;
        end else if (w_lz == '0) begin
          // Carry out of the adder: one right shift, remember the dropped bit.
          w_mant_nxt  = r_mant >> 1;
          w_guard_nxt = r_mant[0];
          w_exp_nxt   = r_exp + EXP_W'(1);
          if (r_exp + EXP_W'(1) >= EXP_W'(255)) begin
            w_exp_nxt  = EXP_W'(255);
            w_mant_nxt = '0;
            w_ovf_nxt  = 1'b1;
          end
        end else if (w_lz != REM_W'(1)) begin
          if (EXP_W'(w_lz) > r_exp) begin
            // Not enough exponent range: stop at the denormal scale.
            w_rem_nxt = REM_W'(r_exp - EXP_W'(1));
            w_exp_nxt = '0;
            w_udf_nxt = 1'b1;
          end else begin
            w_rem_nxt = w_lz - REM_W'(1);
            w_exp_nxt = r_exp - EXP_W'(w_lz - REM_W'(1));
          end
          if (w_rem_nxt != '0) w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_mant_nxt = r_mant << w_step;
        w_rem_nxt  = r_rem - w_step;
        if (w_rem_nxt == '0) w_state_nxt = S_DONE;
      end

      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_sign      = r_sign;
  assign out_exp       = r_exp[7:0];
  assign out_mant      = r_mant[23:0];
  assign out_guard     = r_guard;
  assign out_zero      = r_zero;
  assign out_underflow = r_udf;
  assign out_overflow  = r_ovf;

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Scoreboard bench for fp_norm_sequencer: a driver pushes reference-model results, a monitor
// pops and compares them whenever the DUT presents a result.
module tb_fp_norm_sequencer;

  localparam int unsigned STEP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_guard;
  logic        out_zero;
  logic        out_underflow;
  logic        out_overflow;

  fp_norm_sequencer #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_guard(out_guard), .out_zero(out_zero),
    .out_underflow(out_underflow), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        guard;
    logic        zero;
    logic        udf;
    logic        ovf;
    int          t_first;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  int   ready_mode = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: treat the mantissa as an integer scaled by 2^(e-127-23) and renormalize it.
  function automatic exp_t model(input logic s, input logic [7:0] ie, input logic [24:0] im);
    exp_t   r;
    int     e;
    longint m;
    int     msb;
    int     n;
    int     sh;
    r.sign = s; r.exp = 8'd0; r.mant = 24'd0;
    r.guard = 1'b0; r.zero = 1'b0; r.udf = 1'b0; r.ovf = 1'b0;
    e  = (ie == 8'd0) ? 1 : int'(ie);
    m  = longint'(im);
    sh = 0;
    if (m == 0) begin
      r.zero = 1'b1;
    end else if (m >= 64'd16777216) begin
      r.guard = 1'(m % 2);
      m = m / 2;
      e = e + 1;
      if (e >= 255) begin
        r.exp = 8'd255;
        r.ovf = 1'b1;
      end else begin
        r.exp  = 8'(e);
        r.mant = 24'(m);
      end
    end else begin
      msb = 0;
      for (int i = 0; i < 24; i++) if (m >= (longint'(1) << i)) msb = i;
      n = 23 - msb;
      if (n <= e - 1) begin
        sh = n;
        r.exp = 8'(e - n);
      end else begin
        sh = e - 1;
        r.udf = 1'b1;
      end
      r.mant = 24'(m * (longint'(1) << sh));
    end
    r.t_first = 2 + (sh + int'(STEP) - 1) / int'(STEP);
    return r;
  endfunction

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
    exp_t x;
    bit   ok;
    x = model(s, e, m);
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose, got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    // The accept edge is the next posedge; first valid is seen two negedges later plus shifts.
    x.t_first = x.t_first + ncyc;
    q.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_exp   = 8'($urandom);
    in_mant  = 25'($urandom);
  endtask

  task automatic send_rand();
    int          pos;
    int          sel;
    logic [24:0] m;
    logic [24:0] mask;
    logic [7:0]  e;
    pos = $urandom_range(0, 25);
    if (pos == 25) m = 25'd0;
    else begin
      mask = (25'd1 << pos) - 25'd1;
      m = (25'd1 << pos) | (25'($urandom) & mask);
    end
    sel = $urandom_range(0, 3);
    if (sel == 0)      e = 8'($urandom_range(0, 30));
    else if (sel == 1) e = 8'($urandom_range(240, 254));
    else               e = 8'($urandom_range(0, 254));
    send(1'($urandom), e, m);
  endtask

  // Downstream ready generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on first sight, stability while stalled, payload on handshake.
  initial begin
    bit          seen;
    logic [36:0] snap;
    logic [36:0] cur;
    exp_t        x;
    seen = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        seen = 1'b0;
      end else begin
        cur = {out_sign, out_exp, out_mant, out_guard, out_zero, out_underflow, out_overflow};
        if (!seen) begin
          seen = 1'b1;
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got out_valid=1 expected no pending result at t=%0t", $time);
          end else begin
            chk("latency", 64'(ncyc), 64'(q[0].t_first));
          end
        end else begin
          chk("hold_stable", 64'(cur), 64'(snap));
        end
        snap = cur;
        chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
        chk("flags_exclusive", 64'($countones({out_zero, out_underflow, out_overflow}) > 1), 64'd0);
        if (out_ready) begin
          if (q.size() > 0) begin
            x = q.pop_front();
            chk("sign",      64'(out_sign),      64'(x.sign));
            chk("exp",       64'(out_exp),       64'(x.exp));
            chk("mant",      64'(out_mant),      64'(x.mant));
            chk("guard",     64'(out_guard),     64'(x.guard));
            chk("zero",      64'(out_zero),      64'(x.zero));
            chk("underflow", 64'(out_underflow), 64'(x.udf));
            chk("overflow",  64'(out_overflow),  64'(x.ovf));
          end
          seen = 1'b0;
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 25'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_payload",
        64'({out_sign, out_exp, out_mant, out_guard, out_zero, out_underflow, out_overflow}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed corner cases.
    ready_mode = 0;
    send(1'b0, 8'd127, 25'h0800000);
    send(1'b0, 8'd127, 25'h1800001);
    send(1'b0, 8'd127, 25'h0000001);
    send(1'b0, 8'd5,   25'h0000100);
    send(1'b1, 8'd254, 25'h1000000);
    send(1'b1, 8'd200, 25'h0000000);
    send(1'b0, 8'd0,   25'h0400000);
    send(1'b0, 8'd1,   25'h1FFFFFF);
    send(1'b1, 8'd24,  25'h0000001);
    send(1'b0, 8'd9,   25'h0000001);
    drain();

    // Downstream stall for three cycles while a result is presented.
    ready_mode = 2;
    send(1'b1, 8'd100, 25'h0000F00);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk("stall_valid_seen", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    ready_mode = 0;
    drain();

    // Reset while the shifter is running discards the operand.
    send(1'b0, 8'd127, 25'h0000001);
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midshift_rst_in_ready",  64'(in_ready),  64'd1);
    chk("midshift_rst_out_valid", 64'(out_valid), 64'd0);
    repeat (5) @(negedge clk);

    // Randomized traffic with random back-pressure.
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      send_rand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ready_mode = 0;
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
